// File: rtl/arb_2x1_if.sv
// ---------------------------------------------------------------------------
// arb_2x1_if
//   Handshake bundle for the 2:1 round-robin arbiter.
//   Producer A : A, A_VALID -> arbiter ; A_READY <- arbiter
//   Producer B : B, B_VALID -> arbiter ; B_READY <- arbiter
//   Consumer   : Y, Y_VALID <- arbiter ; Y_READY -> arbiter
//   SEL        : current owner (0 = A, 1 = B) for the downstream mux
//   modport slave  : the arbiter side
//   modport master : the producer/consumer environment side
// ---------------------------------------------------------------------------
interface arb_2x1_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] A;
   logic             A_VALID;
   logic             A_READY;
   logic [WIDTH-1:0] B;
   logic             B_VALID;
   logic             B_READY;
   logic [WIDTH-1:0] Y;
   logic             Y_VALID;
   logic             Y_READY;
   logic             SEL;

   modport slave (
      input  A, A_VALID, B, B_VALID, Y_READY,
      output A_READY, B_READY, Y, Y_VALID, SEL
   );

   modport master (
      output A, A_VALID, B, B_VALID, Y_READY,
      input  A_READY, B_READY, Y, Y_VALID, SEL
   );
endinterface

// File: rtl/arb_2x1.sv
// ---------------------------------------------------------------------------
// arb_2x1
//   Two-channel round-robin arbiter with burst-locked grants. The owner of
//   the shared path transfers BURST beats before arbitration is revisited;
//   the winning word is registered onto Y and SEL steers the downstream mux.
//
//   Parameters : WIDTH - data width of A, B and Y
//                BURST - beats per grant (1..255)
//   Ports      : CLK   - rising-edge clock
//                RST_N - asynchronous active-low reset
//                bus   - arb_2x1_if.slave (A/B producers, Y consumer, SEL)
// ---------------------------------------------------------------------------
module arb_2x1 #(
   parameter int WIDTH = 8,
   parameter int BURST = 4
) (
   input  logic      CLK,
   input  logic      RST_N,
   arb_2x1_if.slave  bus
);

   if (BURST < 1 || BURST > 255) begin : g_burst_range
      $error("arb_2x1: BURST must be in 1..255");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

   state_t           state;
   state_t           grant;
   logic [7:0]       cnt;
   logic             last;        // last owner: 0 = A, 1 = B
   logic [WIDTH-1:0] y_q;
   logic             y_valid_q;
   logic             sel_q;

   logic             space;
   logic             a_rdy;
   logic             b_rdy;
   logic             accept;
   logic             done;
   logic             arb_last;
   logic [WIDTH-1:0] win_data;

   // ------------------------------------------------------------------------
   // Handshake and arbitration decode
   // ------------------------------------------------------------------------
   always_comb begin
      space    = ~y_valid_q | bus.Y_READY;
      a_rdy    = (state == OWN_A) & space;
      b_rdy    = (state == OWN_B) & space;
      accept   = (a_rdy & bus.A_VALID) | (b_rdy & bus.B_VALID);
      win_data = (state == OWN_B) ? bus.B : bus.A;
      done     = accept & (cnt == LAST_BEAT);

      // On the completing edge the pointer is about to become the finishing
      // owner, so arbitrate against that value rather than the stale one.
      arb_last = done ? (state == OWN_B) : last;

      grant = IDLE;
      if (bus.A_VALID && bus.B_VALID) begin
         grant = arb_last ? OWN_A : OWN_B;
      end else if (bus.A_VALID) begin
         grant = OWN_A;
      end else if (bus.B_VALID) begin
         grant = OWN_B;
      end
   end

   // ------------------------------------------------------------------------
   // FSM, beat counter, output register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= 1'b1;
         sel_q     <= 1'b0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            y_q       <= win_data;
            y_valid_q <= 1'b1;
         end else if (bus.Y_READY && y_valid_q) begin
            y_valid_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               state <= grant;
               if (grant == OWN_A) begin
                  sel_q <= 1'b0;
               end else if (grant == OWN_B) begin
                  sel_q <= 1'b1;
               end
            end
            OWN_A, OWN_B: begin
               if (accept) begin
                  if (done) begin
                     cnt   <= '0;
                     last  <= (state == OWN_B);
                     state <= grant;
                     // Going IDLE leaves SEL where it is so the mux does not glitch.
                     if (grant == OWN_A) begin
                        sel_q <= 1'b0;
                     end else if (grant == OWN_B) begin
                        sel_q <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.A_READY = a_rdy;
   assign bus.B_READY = b_rdy;
   assign bus.Y       = y_q;
   assign bus.Y_VALID = y_valid_q;
   assign bus.SEL     = sel_q;

endmodule

// File: tb/tb_arb_2x1.sv
// ---------------------------------------------------------------------------
// tb_arb_2x1
//   Directed bench for arb_2x1: one instance with BURST=4 and one with
//   BURST=1, each on its own interface. Inputs change 1 time unit after a
//   rising edge, outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_arb_2x1;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   arb_2x1_if #(.WIDTH(8)) bus  ();
   arb_2x1_if #(.WIDTH(8)) bus1 ();

   arb_2x1 #(.WIDTH(8), .BURST(4)) dut  (.CLK(clk), .RST_N(rst_n), .bus(bus));
   arb_2x1 #(.WIDTH(8), .BURST(1)) dut1 (.CLK(clk), .RST_N(rst_n), .bus(bus1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      bus.A  = '0; bus.A_VALID  = 1'b0; bus.B  = '0; bus.B_VALID  = 1'b0; bus.Y_READY  = 1'b0;
      bus1.A = '0; bus1.A_VALID = 1'b0; bus1.B = '0; bus1.B_VALID = 1'b0; bus1.Y_READY = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      zero_inputs();
      @(posedge clk);
      #1;
      chk("rst_y",       bus.Y,        32'h0);
      chk("rst_yvalid",  bus.Y_VALID,  32'h0);
      chk("rst_sel",     bus.SEL,      32'h0);
      chk("rst_aready",  bus.A_READY,  32'h0);
      chk("rst_bready",  bus.B_READY,  32'h0);
      chk("rst1_yvalid", bus1.Y_VALID, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] exp_y;
      logic       exp_sel;

      // ---- 1: only A streams 0x01..0x04 -----------------------------------
      do_reset();
      bus.A = 8'h01; bus.A_VALID = 1'b1; bus.Y_READY = 1'b1;
      step();                                    // edge 1: grant A
      chk("t1_aready", bus.A_READY, 32'h1);
      chk("t1_sel",    bus.SEL,     32'h0);
      chk("t1_yvalid", bus.Y_VALID, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         step();                                 // edge i+1: accept word i
         chk("t1_y",      bus.Y,       32'(i));
         chk("t1_yvalid", bus.Y_VALID, 32'h1);
         chk("t1_sel",    bus.SEL,     32'h0);
         bus.A = 8'(i + 1);
         if (i == 4) bus.A_VALID = 1'b0;
      end
      step();                                    // word 4 consumed, nothing new
      chk("t1_drain_yvalid", bus.Y_VALID, 32'h0);
      chk("t1_drain_y",      bus.Y,       32'h04);
      chk("t1_drain_sel",    bus.SEL,     32'h0);
      chk("t1_drain_bready", bus.B_READY, 32'h0);

      // ---- 2: both VALID, BURST=4 round robin ------------------------------
      do_reset();
      bus.A = 8'h55; bus.A_VALID = 1'b1;
      bus.B = 8'hAA; bus.B_VALID = 1'b1;
      bus.Y_READY = 1'b1;
      step();                                    // edge 1: A wins (LAST=B)
      chk("t2_aready", bus.A_READY, 32'h1);
      chk("t2_bready", bus.B_READY, 32'h0);
      chk("t2_sel",    bus.SEL,     32'h0);
      // Edges 2-5 carry A, 6-9 B, 10-13 A, 14-17 B; ownership switches on
      // edges 5, 9, 13, 17.
      for (int k = 2; k <= 17; k++) begin
         step();
         exp_y   = ((((k - 2) / 4) % 2) == 1) ? 8'hAA : 8'h55;
         exp_sel = (((k - 1) / 4) % 2) == 1;
         chk("t2_y",      bus.Y,       32'(exp_y));
         chk("t2_yvalid", bus.Y_VALID, 32'h1);
         chk("t2_sel",    bus.SEL,     32'(exp_sel));
         chk("t2_aready", bus.A_READY, 32'(!exp_sel));
         chk("t2_bready", bus.B_READY, 32'(exp_sel));
      end

      // ---- 3: A stalls mid-burst, B must not steal --------------------------
      do_reset();
      bus.A = 8'h11; bus.A_VALID = 1'b1;
      bus.B = 8'hB1; bus.B_VALID = 1'b1;
      bus.Y_READY = 1'b1;
      step();                                    // edge 1: A owns
      chk("t3_aready", bus.A_READY, 32'h1);
      step(); chk("t3_y1", bus.Y, 32'h11); bus.A = 8'h12;
      step(); chk("t3_y2", bus.Y, 32'h12); bus.A_VALID = 1'b0;
      for (int g = 0; g < 3; g++) begin
         step();
         chk("t3_gap_bready", bus.B_READY, 32'h0);
         chk("t3_gap_aready", bus.A_READY, 32'h1);
         chk("t3_gap_sel",    bus.SEL,     32'h0);
         chk("t3_gap_y",      bus.Y,       32'h12);
         chk("t3_gap_yvalid", bus.Y_VALID, 32'h0);
      end
      bus.A = 8'h13; bus.A_VALID = 1'b1;
      step(); chk("t3_y3", bus.Y, 32'h13); bus.A = 8'h14;
      step(); chk("t3_y4", bus.Y, 32'h14);
      chk("t3_sel_b",   bus.SEL,     32'h1);
      chk("t3_bready",  bus.B_READY, 32'h1);
      chk("t3_aready0", bus.A_READY, 32'h0);
      step(); chk("t3_yb", bus.Y, 32'hB1);

      // ---- 4: backpressure for 5 cycles -------------------------------------
      do_reset();
      bus.A = 8'h21; bus.A_VALID = 1'b1; bus.Y_READY = 1'b1;
      step();                                    // edge 1: A owns
      step(); chk("t4_y1", bus.Y, 32'h21);
      bus.A = 8'h22; bus.Y_READY = 1'b0;
      #1;
      chk("t4_aready_bp", bus.A_READY, 32'h0);
      for (int s = 0; s < 5; s++) begin
         step();
         chk("t4_bp_y",      bus.Y,       32'h21);
         chk("t4_bp_yvalid", bus.Y_VALID, 32'h1);
         chk("t4_bp_aready", bus.A_READY, 32'h0);
         chk("t4_bp_bready", bus.B_READY, 32'h0);
      end
      bus.Y_READY = 1'b1;
      #1;
      chk("t4_aready_resume", bus.A_READY, 32'h1);
      step(); chk("t4_y2", bus.Y, 32'h22); bus.A = 8'h23;
      step(); chk("t4_y3", bus.Y, 32'h23);

      // ---- 5: reset in the middle of a B burst ------------------------------
      do_reset();
      bus.B = 8'h31; bus.B_VALID = 1'b1; bus.Y_READY = 1'b1;
      step();                                    // edge 1: B owns
      chk("t5_sel_b",  bus.SEL,     32'h1);
      chk("t5_bready", bus.B_READY, 32'h1);
      step(); chk("t5_y1", bus.Y, 32'h31); bus.B = 8'h32;
      step(); chk("t5_y2", bus.Y, 32'h32); bus.B = 8'h33;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_y",      bus.Y,       32'h0);
      chk("t5_rst_yvalid", bus.Y_VALID, 32'h0);
      chk("t5_rst_sel",    bus.SEL,     32'h0);
      chk("t5_rst_bready", bus.B_READY, 32'h0);
      chk("t5_rst_aready", bus.A_READY, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.A = 8'h41; bus.A_VALID = 1'b1;
      step();                                    // both VALID: A first
      chk("t5_aready", bus.A_READY, 32'h1);
      chk("t5_bready", bus.B_READY, 32'h0);
      chk("t5_sel_a",  bus.SEL,     32'h0);
      step(); chk("t5_ya", bus.Y, 32'h41);

      // ---- 6: BURST=1 alternates every beat ---------------------------------
      do_reset();
      bus1.A = 8'h55; bus1.A_VALID = 1'b1;
      bus1.B = 8'hAA; bus1.B_VALID = 1'b1;
      bus1.Y_READY = 1'b1;
      step();                                    // edge 1: A owns
      chk("t6_aready", bus1.A_READY, 32'h1);
      chk("t6_sel",    bus1.SEL,     32'h0);
      for (int k = 2; k <= 7; k++) begin
         step();
         exp_y   = ((k % 2) == 0) ? 8'h55 : 8'hAA;
         exp_sel = ((k % 2) == 0);
         chk("t6_y",      bus1.Y,       32'(exp_y));
         chk("t6_yvalid", bus1.Y_VALID, 32'h1);
         chk("t6_sel",    bus1.SEL,     32'(exp_sel));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
